// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage forwarding selector with youngest-stage priority, load-use detection
// and a per-register countdown scoreboard for long-latency ops.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 8,
    parameter int CNT_W   = $clog2(MAX_LAT + 1),
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  src_addr,
    input  logic [NUM_FWD-1:0]         fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0]  fwd_addr,
    input  logic [NUM_FWD-1:0]         fwd_ready,
    input  logic                       issue_valid,
    input  logic [REG_AW-1:0]          issue_rd,
    input  logic [CNT_W-1:0]           issue_lat,
    input  logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic                       busy_any,
    output logic [31:0]                stall_cycles
);

    localparam int NREG = 1 << REG_AW;

    logic [CNT_W-1:0]         r_cnt [NREG];
    logic [31:0]              r_stall_cycles;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic                     w_load_use;
    logic                     w_sb_hit;
    logic                     w_waw;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_busy;
    logic [CNT_W-1:0]         w_lat;

    // Stages are scanned youngest first; the first hit locks the select so an
    // older stage writing the same register can never override it.
    always_comb begin : fwd_search
        logic [REG_AW-1:0] a;
        logic              hit;
        w_sel      = '0;
        w_load_use = 1'b0;
        w_sb_hit   = 1'b0;
        a          = '0;
        hit        = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            a   = src_addr[i*REG_AW +: REG_AW];
            hit = 1'b0;
            if (src_valid[i] && a != '0) begin
                for (int unsigned k = 0; k < NUM_FWD; k++) begin
                    if (!hit && fwd_we[k] && fwd_addr[k*REG_AW +: REG_AW] == a) begin
                        hit                        = 1'b1;
                        w_sel[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
                        if (!fwd_ready[k]) w_load_use = 1'b1;
                    end
                end
                if (r_cnt[a] != '0) w_sb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (r_cnt[r] != '0) w_busy = 1'b1;
        end
    end

    assign w_waw    = issue_valid && issue_rd != '0 && r_cnt[issue_rd] != '0;
    assign w_stall  = !flush && (w_load_use || w_sb_hit || w_waw);
    assign w_accept = issue_valid && !w_stall && !flush && issue_rd != '0 && issue_lat != '0;
    assign w_lat    = (issue_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issue_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_stall_cycles <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (w_accept && issue_rd == REG_AW'(r)) begin
                    r_cnt[r] <= w_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
            if (w_stall && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign fwd_sel      = w_sel;
    assign stall        = w_stall;
    assign busy_any     = w_busy;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
Parametrised successor to the two-port EX-stage forwarding selector. It resolves forwarding for NUM_SRC source operands against NUM_FWD in-flight pipeline stages, with youngest-stage priority. It detects load-use hazards where the matching stage's result is not yet available. It also keeps a per-register countdown scoreboard for long-latency ops (mul/div), raising a single stall toward the hazard/PC logic. It sits in EX beside the register-file read path and drives the operand muxes.

Parameters:
NUM_SRC, 2, number of source operands checked per cycle
NUM_FWD, 2, forwarding stages; index 0 = youngest (MEM), NUM_FWD-1 = oldest (WB)
REG_AW, 5, register address width; register 0 is hardwired zero
MAX_LAT, 8, maximum long-op latency in cycles
CNT_W, $clog2(MAX_LAT+1), scoreboard counter width
SEL_W, $clog2(NUM_FWD+1), per-source select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_valid  in  NUM_SRC  source i is actually read by the instruction in EX
src_addr  in  NUM_SRC*REG_AW  source addresses; source i at [i*REG_AW +: REG_AW]
fwd_we  in  NUM_FWD  stage k will write the register file
fwd_addr  in  NUM_FWD*REG_AW  destination address of stage k
fwd_ready  in  NUM_FWD  stage k's result is valid now (0 for a load still in MEM)
issue_valid  in  1  instruction in EX is a long-latency op being dispatched
issue_rd  in  REG_AW  destination of the long op
issue_lat  in  CNT_W  cycles until the long op's result is forwardable
flush  in  1  squash the EX instruction this cycle
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = regfile, k+1 = forward from stage k
stall  out  1  hold IF/ID/EX this cycle
busy_any  out  1  at least one scoreboard counter is non-zero
stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Clock clk; reset rst is synchronous and active-high. On reset, all counters cnt[r] = 0 and stall_cycles = 0. fwd_sel, stall and busy_any then evaluate to 0 when inputs are idle.
- Forward select (combinational, no latency). For each source i with src_valid[i]=1 and src_addr[i]!=0:
  - Find the lowest k with fwd_we[k]=1, fwd_addr[k]!=0 and fwd_addr[k]==src_addr[i].
  - fwd_sel[i] = k+1. If there is no hit, or src_valid[i]=0, or src_addr[i]=0, fwd_sel[i] = 0.
  - Every matching stage is evaluated. The youngest match always wins; an older match never overrides it.
- Load-use hazard: source i's winning stage k has fwd_ready[k]=0.
- Scoreboard hazard: source i has cnt[src_addr[i]] != 0. This hazard applies regardless of forwarding hits.
- WAW hazard: issue_valid=1, issue_rd!=0 and cnt[issue_rd] != 0.
- stall = !flush AND (any load-use OR scoreboard OR WAW hazard). While flush=1, stall = 0.
- Issue acceptance: accepted when issue_valid=1, stall=0, flush=0, issue_rd!=0 and issue_lat!=0.
  - On acceptance, cnt[issue_rd] <= min(issue_lat, MAX_LAT) at the next edge.
  - That register does not decrement in the same cycle; the load value wins.
- Decrement: every cycle, each non-zero cnt[r] not being loaded decrements by 1. A counter at 0 stays at 0.
- busy_any = OR over all cnt[r] != 0 (combinational from the registers).
- stall_cycles increments by 1 on each cycle with stall=1 and saturates at 32'hFFFF_FFFF.
- flush does not clear the scoreboard. In-flight long ops keep counting down, and their writeback is handled by the commit path.
- A reset asserted mid-operation clears all counters on that edge. The stall from a pending long op drops in the following cycle.
- With NUM_SRC=2, NUM_FWD=2 and no long ops, fwd_sel encoding is 0 = regfile, 1 = MEM, 2 = WB. This matches the existing EX operand mux encoding.

Test Plan:
- Youngest-wins priority: src0=x5, fwd_we=2'b11, fwd_addr MEM=x5 and WB=x5, fwd_ready=2'b11 -> fwd_sel[0]=1, stall=0. Repeat with MEM=x6 -> fwd_sel[0]=2.
- x0 and invalid sources: src0=x0 with MEM writing x0 -> fwd_sel[0]=0. Set src_valid[1]=0 with src1 matching WB -> fwd_sel[1]=0. Both cases stall=0.
- Load-use: src1=x7, MEM writes x7 with fwd_ready[0]=0 -> stall=1, fwd_sel[1]=1, stall_cycles +1. Next cycle fwd_ready[0]=1 -> stall=0.
- Scoreboard countdown: issue x9 with lat=3 -> cnt[x9] reads 3,2,1,0 on the following edges. While cnt!=0, src0=x9 -> stall=1. Once cnt=0, stall=0. busy_any tracks the counter.
- Lat clamp and WAW: issue x4 with lat=15 (MAX_LAT=8) -> cnt=8. A second issue to x4 while busy -> stall=1 and the issue is not accepted (cnt keeps decrementing). issue_lat=0 -> no entry.
- Flush and reset: a hazard with flush=1 -> stall=0 and the issue is ignored. Asserting rst while cnt[x3]=5 -> all counters 0 and stall_cycles=0 on the next edge.
